// File: rtl/mmio_fabric_if.sv
// mmio_fabric_if: CPU-side request/response and peripheral-side strobe signals of mmio_fabric.
// master = CPU plus peripherals driving the fabric; slave = the fabric itself.
interface mmio_fabric_if #(
  parameter int N_SLAVES = 9
);
  logic                  m_req;
  logic [31:0]           m_addr;
  logic [31:0]           m_wdata;
  logic [3:0]            m_wenable;
  logic                  m_ready;
  logic [31:0]           m_rdata;
  logic                  m_err;
  logic [N_SLAVES-1:0]   s_sel;
  logic [31:0]           s_addr;
  logic [31:0]           s_wdata;
  logic [3:0]            s_wenable;
  logic [32*N_SLAVES-1:0] s_rdata;
  logic [N_SLAVES-1:0]   s_ready;
  modport master (
    output m_req, m_addr, m_wdata, m_wenable, s_rdata, s_ready,
    input  m_ready, m_rdata, m_err, s_sel, s_addr, s_wdata, s_wenable
  );
  modport slave (
    input  m_req, m_addr, m_wdata, m_wenable, s_rdata, s_ready,
    output m_ready, m_rdata, m_err, s_sel, s_addr, s_wdata, s_wenable
  );
endinterface

// File: rtl/mmio_fabric.sv
// mmio_fabric: address-decoding MMIO fabric with a registered request/ready handshake to N slaves.
// Define MMIO_FABRIC_TIMEOUT_EN to abort accesses whose slave stalls for TIMEOUT cycles.
module mmio_fabric #(
  parameter int N_SLAVES = 9,
  parameter int DEC_HI = 31,
  parameter int DEC_W = 4,
  parameter logic [N_SLAVES*DEC_W-1:0] REGION_BASE = 36'hACA984320,
  parameter logic [N_SLAVES*DEC_W-1:0] REGION_MASK = 36'hBEFFFEFFF,
  parameter int TIMEOUT = 15
) (
  input logic clk,
  input logic rst_n,
  mmio_fabric_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  state_t state, state_nx;
  logic [N_SLAVES-1:0] sel, sel_nx, hit;
  logic [31:0] addr, wdata, rdata, rdata_nx, sel_rdata;
  logic [3:0] wen;
  logic [DEC_W-1:0] field;
  logic err, err_nx, rdy_sel, expired;
  assign field = bus.m_addr[DEC_HI -: DEC_W];
  // Scan from the top so the lowest matching index is left standing.
  always_comb begin
    hit = '0;
    for (int i = N_SLAVES - 1; i >= 0; i--)
      if ((field & REGION_MASK[i*DEC_W +: DEC_W]) == (REGION_BASE[i*DEC_W +: DEC_W] & REGION_MASK[i*DEC_W +: DEC_W])) begin
        hit = '0;
        hit[i] = 1'b1;
      end
  end
  always_comb begin
    sel_rdata = '0;
    for (int i = 0; i < N_SLAVES; i++)
      sel_rdata = sel_rdata | (sel[i] ? bus.s_rdata[i*32 +: 32] : 32'd0);
  end
  assign rdy_sel = |(sel & bus.s_ready);
`ifdef MMIO_FABRIC_TIMEOUT_EN
  logic [7:0] cnt;
  // cnt holds the number of completed ACCESS cycles; expiry fires on the TIMEOUT-th one.
  assign expired = (cnt + 8'd1) == 8'(TIMEOUT);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else cnt <= (state == ACCESS) ? cnt + 8'd1 : 8'd0;
`else
  logic unused_timeout;
  assign unused_timeout = ^8'(TIMEOUT);
  assign expired = 1'b0;
`endif
  always_comb begin
    state_nx = state;
    sel_nx = sel;
    rdata_nx = rdata;
    err_nx = err;
    case (state)
      IDLE: if (bus.m_req) begin
        state_nx = |hit ? ACCESS : RESP;
        sel_nx = hit;
        err_nx = ~|hit;
        rdata_nx = '0;
      end
      ACCESS: if (rdy_sel || expired) begin
        state_nx = RESP;
        sel_nx = '0;
        err_nx = ~rdy_sel;
        rdata_nx = rdy_sel ? sel_rdata : 32'hDEAD_BEEF;
      end
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      sel <= '0;
      rdata <= '0;
      err <= 1'b0;
      addr <= '0;
      wdata <= '0;
      wen <= '0;
    end else begin
      state <= state_nx;
      sel <= sel_nx;
      rdata <= rdata_nx;
      err <= err_nx;
      if (state == IDLE && bus.m_req) begin
        addr <= bus.m_addr;
        wdata <= bus.m_wdata;
        wen <= bus.m_wenable;
      end
    end
  assign bus.m_ready = state == RESP;
  assign bus.m_rdata = rdata;
  assign bus.m_err = err;
  assign bus.s_sel = sel;
  assign bus.s_addr = addr;
  assign bus.s_wdata = wdata;
  assign bus.s_wenable = |sel ? wen : 4'd0;
endmodule

// File: tb/tb_mmio_fabric.sv
// tb_mmio_fabric: randomized self-checking bench for mmio_fabric against a latency/decode model.
// Honours MMIO_FABRIC_TIMEOUT_EN the same way as the design build.
module tb_mmio_fabric;
  localparam int N = 9;
  localparam int TO = 15;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int total = 0;
  int bad = 0;
  int base [N] = '{'h0, 'h2, 'h3, 'h4, 'h8, 'h9, 'hA, 'hC, 'hA};
  int mask [N] = '{'hF, 'hF, 'hF, 'hE, 'hF, 'hF, 'hF, 'hE, 'hB};
  mmio_fabric_if #(.N_SLAVES(N)) bus ();
  mmio_fabric #(.N_SLAVES(N), .TIMEOUT(TO)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask
  function automatic int ref_dec(input logic [31:0] a);
    for (int i = 0; i < N; i++)
      if ((int'(a[31:28]) & mask[i]) == (base[i] & mask[i])) return i;
    return -1;
  endfunction
  // One master transaction; slave readies on ACCESS cycle d (never, if d is out of reach).
  task automatic access(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] we,
                        input int d, input logic [31:0] rd, input bit b2b);
    int idx, n, lat, t;
    bit got;
    logic err_e;
    logic [31:0] rd_e;
    logic [N-1:0] sel_e;
    idx = ref_dec(a);
    sel_e = '0;
    if (idx >= 0) sel_e[idx] = 1'b1;
    n = d + 1;
    err_e = 1'b0;
    rd_e = rd;
    if (idx < 0) begin
      n = 0;
      err_e = 1'b1;
      rd_e = 32'd0;
    end
`ifdef MMIO_FABRIC_TIMEOUT_EN
    else if (n > TO) begin
      n = TO;
      err_e = 1'b1;
      rd_e = 32'hDEAD_BEEF;
    end
`endif
    lat = n + 1;
    if (!b2b) @(negedge clk);
    for (int i = 0; i < N; i++) bus.s_rdata[i*32 +: 32] = $urandom;
    if (idx >= 0) bus.s_rdata[idx*32 +: 32] = rd;
    bus.s_ready = N'($urandom) & ~sel_e;
    bus.m_req = 1'b1;
    bus.m_addr = a;
    bus.m_wdata = wd;
    bus.m_wenable = we;
    if (b2b) begin
      @(posedge clk);
      @(negedge clk);
      chk("b2b_sel", 32'(bus.s_sel), 32'd0);
      chk("b2b_ready", 32'(bus.m_ready), 32'd0);
    end
    @(posedge clk);
    t = 0;
    got = 1'b0;
    while (!got && t < lat + 4) begin
      @(negedge clk);
      if (bus.m_ready) got = 1'b1;
      else begin
        chk("sel", 32'(bus.s_sel), 32'(sel_e));
        chk("swen", 32'(bus.s_wenable), 32'(we));
        chk("saddr", bus.s_addr, a);
        chk("swdata", bus.s_wdata, wd);
        bus.s_ready = N'($urandom) & ~sel_e;
        if (t == d) bus.s_ready = bus.s_ready | sel_e;
        bus.m_addr = $urandom;
        bus.m_wdata = $urandom;
        t++;
      end
    end
    bus.m_req = 1'b0;
    chk("latency", 32'(got ? t + 1 : 0), 32'(lat));
    chk("err", 32'(bus.m_err), 32'(err_e));
    chk("rdata", bus.m_rdata, rd_e);
    chk("sel_done", 32'(bus.s_sel), 32'd0);
    chk("swen_done", 32'(bus.s_wenable), 32'd0);
  endtask
  initial begin
    #300000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end
  initial begin
    logic seen;
    bus.m_req = 1'b0;
    bus.m_addr = '0;
    bus.m_wdata = '0;
    bus.m_wenable = '0;
    bus.s_rdata = '0;
    bus.s_ready = '0;
    repeat (2) @(negedge clk);
    chk("rst_ready", 32'(bus.m_ready), 32'd0);
    chk("rst_err", 32'(bus.m_err), 32'd0);
    chk("rst_rdata", bus.m_rdata, 32'd0);
    chk("rst_sel", 32'(bus.s_sel), 32'd0);
    chk("rst_saddr", bus.s_addr, 32'd0);
    chk("rst_swdata", bus.s_wdata, 32'd0);
    chk("rst_swen", 32'(bus.s_wenable), 32'd0);
    rst_n = 1'b1;
    access(32'h2000_0000, 32'h0, 4'h0, 0, 32'h1234_5678, 1'b0);
    access(32'hC000_0001, 32'hCAFE_F00D, 4'b0001, 3, 32'h0BAD_0BAD, 1'b0);
    access(32'hF000_0000, 32'h1111_2222, 4'h0, 0, 32'h5555_AAAA, 1'b0);
    access(32'h8000_0000, 32'h0, 4'h0, TO - 1, 32'h7777_8888, 1'b0);
    access(32'h9000_0000, 32'h0, 4'h0, 1000, 32'h9999_0000, 1'b0);
    access(32'hA000_0000, 32'h1, 4'hF, 1, 32'h0123_4567, 1'b0);
    access(32'hE000_0000, 32'h2, 4'h3, 0, 32'h89AB_CDEF, 1'b1);
    access(32'h5000_0000, 32'h3, 4'h0, 2, 32'h2468_ACE0, 1'b1);
    for (int k = 0; k < 60; k++) begin
      int d;
      d = ($urandom_range(0, 7) == 0) ? (($urandom_range(0, 1) == 1) ? TO - 1 : TO + 3) : $urandom_range(0, 5);
      access($urandom, $urandom, ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'h0, d, $urandom,
             $urandom_range(0, 3) == 0);
    end
    @(negedge clk);
    bus.m_req = 1'b1;
    bus.m_addr = 32'h8000_0000;
    bus.m_wdata = 32'hA5A5_A5A5;
    bus.m_wenable = 4'hF;
    bus.s_ready = '0;
    @(posedge clk);
    repeat (2) @(negedge clk);
    chk("pre_rst_sel", 32'(bus.s_sel), 32'h10);
    rst_n = 1'b0;
    bus.m_req = 1'b0;
    #1;
    chk("arst_sel", 32'(bus.s_sel), 32'd0);
    chk("arst_swen", 32'(bus.s_wenable), 32'd0);
    chk("arst_saddr", bus.s_addr, 32'd0);
    chk("arst_swdata", bus.s_wdata, 32'd0);
    chk("arst_ready", 32'(bus.m_ready), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.s_ready = '1;
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      seen = seen | bus.m_ready | (|bus.s_sel);
    end
    chk("post_rst_quiet", 32'(seen), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
